// File: rtl/nvdla_car_pkg.sv
// nvdla_car_pkg: shared FSM encoding, default timing constants and parameter range check for the CAR reset sequencer
package nvdla_car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } car_state_e;

  localparam int DEF_HOLD    = 16;
  localparam int DEF_STAGGER = 4;
  localparam int DEF_TIMEOUT = 255;

  // True when every timing constant fits the counter and the partition count is supported
  function automatic bit params_ok(input int np, input int hold, input int stag, input int tmo, input int cw);
    int mx;
    mx = (hold > stag) ? hold : stag;
    mx = (tmo > mx) ? tmo : mx;
    return np >= 1 && np <= 8 && hold >= 1 && stag >= 1 && tmo >= 1 && cw >= 1 && cw <= 30 && mx < (1 << cw);
  endfunction

endpackage

// File: rtl/nvdla_car_down_cnt.sv
// nvdla_car_down_cnt: loadable down-counter with zero flag shared by the drain, hold and stagger timers
module nvdla_car_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load has priority over decrement
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= i_load ? i_val : (i_dec ? r_cnt - W'(1) : r_cnt);

  assign o_zero = r_cnt == '0;

endmodule

// File: rtl/nvdla_core_reset_seq.sv
// nvdla_core_reset_seq: drains, asserts and stagger-releases per-partition software core resets
module nvdla_core_reset_seq
  import nvdla_car_pkg::*;
#(
  parameter int NUM_PART       = 4,
  parameter int HOLD_CYCLES    = DEF_HOLD,
  parameter int STAGGER_CYCLES = DEF_STAGGER,
  parameter int DRAIN_TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic                nvdla_clk,
  input  logic                dla_reset_rstn,
  input  logic                sw_reset_req,
  input  logic [NUM_PART-1:0] part_idle,
  input  logic                err_clr,
  output logic [NUM_PART-1:0] core_reset_rstn,
  output logic                reset_busy,
  output logic                reset_done,
  output logic                timeout_err
);

  if (!params_ok(NUM_PART, HOLD_CYCLES, STAGGER_CYCLES, DRAIN_TIMEOUT, CNT_W)) begin : g_param_err
    $error("nvdla_core_reset_seq: parameter out of range");
  end

  localparam int IDX_W = $clog2(NUM_PART + 1);

  car_state_e          r_state;
  car_state_e          w_nxt;
  logic [NUM_PART-1:0] r_rstn;
  logic [IDX_W-1:0]    r_idx;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                w_zero;
  logic                w_load;
  logic                w_dec;
  logic [CNT_W-1:0]    w_val;
  logic                w_start;
  logic                w_to_assert;
  logic                w_timeout;
  logic                w_to_release;
  logic                w_last;
  logic                w_step;
  logic                w_finish;

  assign w_start      = r_state == ST_IDLE && sw_reset_req;
  assign w_to_assert  = r_state == ST_DRAIN && (&part_idle || w_zero);
  assign w_timeout    = r_state == ST_DRAIN && !(&part_idle) && w_zero;
  assign w_to_release = r_state == ST_ASSERT && w_zero;
  assign w_last       = r_idx == IDX_W'(NUM_PART - 1);
  assign w_step       = r_state == ST_RELEASE && w_zero && !w_last;
  assign w_finish     = r_state == ST_RELEASE && w_zero && w_last;

  // Next-state selection; requests outside IDLE fall through untouched
  always_comb begin
    w_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:    w_nxt = sw_reset_req ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:   w_nxt = w_to_assert ? ST_ASSERT : ST_DRAIN;
      ST_ASSERT:  w_nxt = w_zero ? ST_RELEASE : ST_ASSERT;
      ST_RELEASE: w_nxt = w_finish ? ST_DONE : ST_RELEASE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  // Timer control: each phase reloads its period minus one so the zero flag marks its final cycle
  always_comb begin
    w_load = w_start || w_to_assert || w_to_release || w_step;
    w_val  = w_start ? CNT_W'(DRAIN_TIMEOUT - 1) : (w_to_assert ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(STAGGER_CYCLES - 1));
    w_dec  = !w_load && !w_zero && (r_state == ST_DRAIN || r_state == ST_ASSERT || r_state == ST_RELEASE);
  end

  nvdla_car_down_cnt #(.W(CNT_W)) u_cnt (
    .clk    (nvdla_clk),
    .rst_n  (dla_reset_rstn),
    .i_load (w_load),
    .i_val  (w_val),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  // State, release vector and status flags; released bits fill from bit 0 upward and never drop
  always_ff @(posedge nvdla_clk or negedge dla_reset_rstn)
    if (!dla_reset_rstn) begin
      r_state <= ST_IDLE;
      r_rstn  <= '1;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_rstn  <= w_to_assert ? '0 : (w_to_release ? NUM_PART'(1) : (w_step ? (r_rstn << 1) | NUM_PART'(1) : r_rstn));
      r_idx   <= w_to_release ? '0 : (w_step ? r_idx + IDX_W'(1) : r_idx);
      r_busy  <= w_start ? 1'b1 : (w_finish ? 1'b0 : r_busy);
      r_done  <= w_finish;
      r_err   <= w_timeout || (r_err && !err_clr);
    end

  assign core_reset_rstn = r_rstn;
  assign reset_busy      = r_busy;
  assign reset_done      = r_done;
  assign timeout_err     = r_err;

endmodule

// File: tb/tb_nvdla_core_reset_seq.sv
// tb_nvdla_core_reset_seq: scoreboard bench; stimulus queues expected output changes, a monitor checks each change
module tb_nvdla_core_reset_seq;

  logic       clk;
  logic       rstn;
  logic       req;
  logic       req1;
  logic [3:0] idle;
  logic       err_clr;
  logic [3:0] rst_o;
  logic       busy;
  logic       done;
  logic       err;
  logic [0:0] rst1_o;
  logic       busy1;
  logic       done1;
  logic       err1;

  typedef struct {
    int          cyc;
    logic [10:0] val;
  } ev_t;

  ev_t         q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          c0;
  logic [10:0] prev = 'x;
  localparam logic [3:0] D1_IDLE = 4'b1000;

  nvdla_core_reset_seq dut (
    .nvdla_clk       (clk),
    .dla_reset_rstn  (rstn),
    .sw_reset_req    (req),
    .part_idle       (idle),
    .err_clr         (err_clr),
    .core_reset_rstn (rst_o),
    .reset_busy      (busy),
    .reset_done      (done),
    .timeout_err     (err)
  );

  nvdla_core_reset_seq #(.NUM_PART(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) dut1 (
    .nvdla_clk       (clk),
    .dla_reset_rstn  (rstn),
    .sw_reset_req    (req1),
    .part_idle       (1'b1),
    .err_clr         (err_clr),
    .core_reset_rstn (rst1_o),
    .reset_busy      (busy1),
    .reset_done      (done1),
    .timeout_err     (err1)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every change of the observed outputs must match the next queued expectation, cycle included
  always @(negedge clk) begin
    logic [10:0] obs;
    ev_t         e;
    obs = {rst_o, busy, done, err, rst1_o, busy1, done1, err1};
    if (obs !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d value %b, required no change", cyc, obs);
      end else begin
        e = q.pop_front();
        if ((e.cyc >= 0 && e.cyc != cyc) || e.val !== obs) begin
          errors++;
          $display("FAIL output_change: cycle %0d value %b, required cycle %0d value %b", cyc, obs, e.cyc, e.val);
        end
      end
      prev = obs;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [6:0] m);
    q.push_back('{c, {m, D1_IDLE}});
  endtask

  task automatic push1(input int c, input logic [3:0] d);
    q.push_back('{c, {4'hF, 3'b000, d}});
  endtask

  task automatic push_main(input int c, input int dl, input logic e0, input logic e1);
    int a;
    a = c + 1 + dl;
    push(c + 1,  {4'hF, 2'b10, e0});
    push(a,      {4'h0, 2'b10, e1});
    push(a + 16, {4'h1, 2'b10, e1});
    push(a + 20, {4'h3, 2'b10, e1});
    push(a + 24, {4'h7, 2'b10, e1});
    push(a + 28, {4'hF, 2'b10, e1});
    push(a + 32, {4'hF, 2'b01, e1});
    push(a + 33, {4'hF, 2'b00, e1});
  endtask

  task automatic pulse_req();
    req = 1;
    wait_cyc(1);
    req = 0;
  endtask

  initial begin
    rstn = 1; req = 0; req1 = 0; idle = 4'hF; err_clr = 0;
    q.push_back('{-1, {4'hF, 3'b000, D1_IDLE}});
    #2 rstn = 0;
    wait_cyc(3);
    rstn = 1;
    wait_cyc(2);
    c0 = cyc; push_main(c0, 1, 0, 0); pulse_req(); wait_until(c0 + 40);
    idle = 4'h7;
    c0 = cyc; push_main(c0, 11, 0, 0); pulse_req(); wait_until(c0 + 11);
    idle = 4'hF; wait_until(c0 + 50);
    idle = 4'h0;
    c0 = cyc; push_main(c0, 255, 0, 1); pulse_req(); wait_until(c0 + 300);
    c0 = cyc; push_main(c0, 255, 1, 1); pulse_req(); wait_until(c0 + 255);
    err_clr = 1; wait_cyc(1); err_clr = 0; wait_until(c0 + 300);
    idle = 4'hF;
    c0 = cyc; push(c0 + 1, {4'hF, 3'b000});
    err_clr = 1; wait_cyc(1); err_clr = 0; wait_cyc(3);
    c0 = cyc; push_main(c0, 1, 0, 0); pulse_req();
    wait_until(c0 + 5);  pulse_req();
    wait_until(c0 + 20); pulse_req();
    wait_until(c0 + 34); pulse_req();
    wait_until(c0 + 60);
    c0 = cyc;
    push(c0 + 1,  {4'hF, 3'b100});
    push(c0 + 2,  {4'h0, 3'b100});
    push(c0 + 18, {4'h1, 3'b100});
    push(c0 + 22, {4'h3, 3'b100});
    push(c0 + 23, {4'hF, 3'b000});
    pulse_req(); wait_until(c0 + 23);
    rstn = 0; wait_cyc(3); rstn = 1; wait_cyc(2);
    c0 = cyc; push_main(c0, 1, 0, 0); pulse_req(); wait_until(c0 + 40);
    c0 = cyc;
    push1(c0 + 1, 4'b1100);
    push1(c0 + 2, 4'b0100);
    push1(c0 + 3, 4'b1100);
    push1(c0 + 4, 4'b1010);
    push1(c0 + 5, 4'b1000);
    req1 = 1; wait_cyc(1); req1 = 0; wait_until(c0 + 10);
    wait_cyc(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected changes never seen, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
